// File: rtl/if_id_pipe_reg_if.sv
// Fetch/decode handshake bundle for the IF->ID pipeline register.
// The slave modport is the register's own view; master is the surrounding pipeline.
interface if_id_pipe_reg_if #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 16
);
   logic               if_valid_i;
   logic [PC_W-1:0]    if_pc_i;
   logic [INSTR_W-1:0] if_instr_i;
   logic               if_ready_o;
   logic               id_valid_o;
   logic [PC_W-1:0]    id_pc_o;
   logic [INSTR_W-1:0] id_instr_o;
   logic               id_ready_i;
   logic               flush_i;
   logic [CNT_W-1:0]   stall_cnt_o;

   modport master (
      output if_valid_i, if_pc_i, if_instr_i, id_ready_i, flush_i,
      input  if_ready_o, id_valid_o, id_pc_o, id_instr_o, stall_cnt_o
   );

   modport slave (
      input  if_valid_i, if_pc_i, if_instr_i, id_ready_i, flush_i,
      output if_ready_o, id_valid_o, id_pc_o, id_instr_o, stall_cnt_o
   );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register with a two-entry skid buffer, synchronous flush and a
// saturating back-pressure counter; if_ready_o depends on the state register only.
module if_id_pipe_reg #(
   parameter int                 PC_W      = 32,
   parameter int                 INSTR_W   = 32,
   parameter logic [PC_W-1:0]    RESET_PC  = {PC_W{1'b0}},
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013),
   parameter int                 CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   if_id_pipe_reg_if.slave   bus
);

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_FULL  = 2'b01;
   localparam logic [1:0] ST_SKID  = 2'b10;

   logic [1:0]         state_r;
   logic [1:0]         state_nxt_s;
   logic [PC_W-1:0]    main_pc_r;
   logic [INSTR_W-1:0] main_instr_r;
   logic [PC_W-1:0]    skid_pc_r;
   logic [INSTR_W-1:0] skid_instr_r;
   logic [CNT_W-1:0]   stall_cnt_r;

   logic id_valid_s;
   logic if_ready_s;
   logic in_fire_s;
   logic out_fire_s;
   logic stall_s;
   logic load_main_in_s;
   logic load_main_skid_s;
   logic load_skid_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_W'(1);
      end
   endfunction

   assign id_valid_s = (state_r != ST_EMPTY);
   assign if_ready_s = (state_r != ST_SKID);
   assign in_fire_s  = bus.if_valid_i & if_ready_s;
   assign out_fire_s = id_valid_s & bus.id_ready_i;
   assign stall_s    = id_valid_s & ~bus.id_ready_i;

   // Next-state and data-load decode; flush wins over both handshakes.
   always_comb begin
      state_nxt_s      = state_r;
      load_main_in_s   = 1'b0;
      load_main_skid_s = 1'b0;
      load_skid_s      = 1'b0;
      if (bus.flush_i) begin
         state_nxt_s = ST_EMPTY;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  state_nxt_s    = ST_FULL;
                  load_main_in_s = 1'b1;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (in_fire_s && out_fire_s) begin
                  state_nxt_s    = ST_FULL;
                  load_main_in_s = 1'b1;
               end else if (in_fire_s) begin
                  state_nxt_s = ST_SKID;
                  load_skid_s = 1'b1;
               end else if (out_fire_s) begin
                  state_nxt_s = ST_EMPTY;
               end else begin
                  state_nxt_s = ST_FULL;
               end
            end
            ST_SKID: begin
               // if_ready_o is low here, so only the drain can happen
               if (out_fire_s) begin
                  state_nxt_s      = ST_FULL;
                  load_main_skid_s = 1'b1;
               end else begin
                  state_nxt_s = ST_SKID;
               end
            end
            default: begin
               state_nxt_s = ST_EMPTY;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Main and skid data registers; they hold unless a load is decoded.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_pc_r    <= RESET_PC;
         main_instr_r <= NOP_INSTR;
         skid_pc_r    <= RESET_PC;
         skid_instr_r <= NOP_INSTR;
      end else begin
         if (load_main_in_s) begin
            main_pc_r    <= bus.if_pc_i;
            main_instr_r <= bus.if_instr_i;
         end else if (load_main_skid_s) begin
            main_pc_r    <= skid_pc_r;
            main_instr_r <= skid_instr_r;
         end else begin
            main_pc_r    <= main_pc_r;
            main_instr_r <= main_instr_r;
         end
         if (load_skid_s) begin
            skid_pc_r    <= bus.if_pc_i;
            skid_instr_r <= bus.if_instr_i;
         end else begin
            skid_pc_r    <= skid_pc_r;
            skid_instr_r <= skid_instr_r;
         end
      end
   end

   // Back-pressure counter; flush does not touch it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (stall_s) begin
         stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign bus.id_valid_o  = id_valid_s;
   assign bus.if_ready_o  = if_ready_s;
   assign bus.id_pc_o     = main_pc_r;
   assign bus.id_instr_o  = main_instr_r;
   assign bus.stall_cnt_o = stall_cnt_r;

endmodule
